// File: rtl/partition_sweep_pkg.sv
// -----------------------------------------------------------------------------
// partition_sweep_pkg
//   Shared definitions for the partition sweep controller: default widths,
//   the sweep FSM state encoding and a constant-foldable ceil(log2) helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package partition_sweep_pkg;

   localparam int DEF_NUM_IN     = 7;
   localparam int DEF_NUM_OUT    = 4;
   localparam int DEF_SETTLE_CYC = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRIVE   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_EMIT    = 3'd4,
      ST_FINISH  = 3'd5
   } sweep_state_t;

   // ceil(log2(value)), never below 1 so it is always usable as a vector width
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/partition_popcount.sv
// -----------------------------------------------------------------------------
// partition_popcount
//   Combinational population count of the exact/approximate difference vector,
//   i.e. the Hamming distance of one partition evaluation.
//   Ports:
//     bits   in  NUM_OUT  difference vector (exact ^ approx)
//     count  out CW       number of set bits
// -----------------------------------------------------------------------------
module partition_popcount
#(
   parameter int NUM_OUT = 4,
   parameter int CW      = 3
) (
   input  logic [NUM_OUT-1:0] bits,
   output logic [CW-1:0]      count
);

   // sum the individual difference bits
   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// partition_sweep_ctrl
//   Drives every input vector 0..2^NUM_IN-1 into an exact and an approximate
//   combinational partition, captures both outputs after a settle time and
//   streams one (vector, approx output, mismatch) record per vector over a
//   valid/ready interface while accumulating mismatch count and Hamming sum.
//   Ports:
//     clk        in   1            rising-edge clock
//     rst_n      in   1            asynchronous active-low reset
//     start      in   1            begins a sweep when idle
//     abort      in   1            ends the sweep without a done pulse
//     pi         out  NUM_IN       vector driven to both partitions
//     po_exact   in   NUM_OUT      exact partition output
//     po_approx  in   NUM_OUT      approximate partition output
//     out_valid  out  1            record valid
//     out_ready  in   1            sink accepts the record
//     out_vec    out  NUM_IN       vector of the record
//     out_po     out  NUM_OUT      captured approximate output
//     out_mis    out  1            exact/approx mismatch for this vector
//     busy       out  1            sweep in progress
//     done       out  1            pulse after the last record is accepted
//     err_cnt    out  NUM_IN+1     number of mismatching vectors
//     hd_sum     out  NUM_IN+CW    sum of Hamming distances
// -----------------------------------------------------------------------------
module partition_sweep_ctrl
   import partition_sweep_pkg::*;
#(
   parameter int  NUM_IN     = DEF_NUM_IN,
   parameter int  NUM_OUT    = DEF_NUM_OUT,
   parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
   localparam int CW         = clog2(NUM_OUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [NUM_IN-1:0]    pi,
   input  logic [NUM_OUT-1:0]   po_exact,
   input  logic [NUM_OUT-1:0]   po_approx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_IN-1:0]    out_vec,
   output logic [NUM_OUT-1:0]   out_po,
   output logic                 out_mis,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_IN:0]      err_cnt,
   output logic [NUM_IN+CW-1:0] hd_sum
);

   localparam int SCW = clog2(SETTLE_CYC + 1);

   // vec carries one extra bit so the last-vector compare can never alias after a wrap
   localparam logic [NUM_IN:0]  LAST_VEC    = {1'b0, {NUM_IN{1'b1}}};
   localparam logic [NUM_IN:0]  VEC_ONE     = (NUM_IN + 1)'(1);
   localparam logic [SCW-1:0]   SETTLE_INIT = SCW'(SETTLE_CYC);
   localparam logic [SCW-1:0]   SETTLE_ONE  = SCW'(1);

   sweep_state_t         state;
   logic [NUM_IN:0]      vec;
   logic [SCW-1:0]       settle_cnt;
   logic [NUM_OUT-1:0]   diff;
   logic [CW-1:0]        hd;
   logic                 mis;

   assign diff = po_exact ^ po_approx;
   assign mis  = |diff;

   partition_popcount #(
      .NUM_OUT (NUM_OUT),
      .CW      (CW)
   ) u_popcount (
      .bits  (diff),
      .count (hd)
   );

   // sweep FSM, vector/settle counters, record registers and error accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         pi         <= '0;
         out_valid  <= 1'b0;
         out_vec    <= '0;
         out_po     <= '0;
         out_mis    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_cnt    <= '0;
         hd_sum     <= '0;
      end else if (abort) begin
         // partial accumulators and the last record stay visible after an abort
         state     <= ST_IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  err_cnt <= '0;
                  hd_sum  <= '0;
                  vec     <= '0;
                  busy    <= 1'b1;
                  state   <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               // pi only ever moves here, so both partitions see a stable vector until the handshake
               pi         <= vec[NUM_IN-1:0];
               settle_cnt <= SETTLE_INIT;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt - SETTLE_ONE;
               if (settle_cnt <= SETTLE_ONE) begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               out_vec   <= vec[NUM_IN-1:0];
               out_po    <= po_approx;
               out_mis   <= mis;
               err_cnt   <= err_cnt + {{NUM_IN{1'b0}}, mis};
               hd_sum    <= hd_sum + {{NUM_IN{1'b0}}, hd};
               out_valid <= 1'b1;
               state     <= ST_EMIT;
            end
            ST_EMIT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (vec == LAST_VEC) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_FINISH;
                  end else begin
                     vec   <= vec + VEC_ONE;
                     state <= ST_DRIVE;
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
